fir_share_arb: RTL and testbench



---
 rtl/fir_share_arb.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_fir_share_arb.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_share_arb.sv
// -----------------------------------------------------------------------------
// fir_share_arb
//
// Shares one FIR engine between the left and right 24-bit audio streams.
// Samples from the two inputs are arbitrated round-robin, narrowed to 16 bits
// and issued to the FIR engine. The channel of each issued sample is recorded
// in a tag FIFO, so each 24-bit FIR result can be routed back to its channel's
// output FIFO. The FIR engine has no backpressure. A per-channel credit counter
// therefore limits issues to the number of output FIFO slots that are
// guaranteed to be free when the results come back.
//
// Optional feature (compile-time macro FIR_SHARE_ARB_ROUND_EN):
//   defined   : fir_in_data = in_data[23:8] + in_data[7], saturating at 16'h7FFF
//   undefined : fir_in_data = in_data[23:8] (plain truncation)
//
// Parameters
//   CREDITS      samples per channel in flight plus buffered; output FIFO depth
//                (power of 2, 2..16)
//   ISSUE_GAP    minimum idle cycles between consecutive FIR issues
//   DRAIN_CYCLES cycles after reset during which results are discarded and
//                nothing is issued
//
// Ports
//   clk_clk, reset_reset                 clock, synchronous active-high reset
//   left/right_in_data/valid/ready       24-bit sample inputs (valid/ready)
//   fir_in_data/valid/error              16-bit issue to FIR (error tied 0)
//   fir_out_data/valid/error             24-bit FIR result, in issue order
//   left/right_out_data/valid/ready      24-bit filtered outputs (valid/ready)
//   err_count                            saturating count of errored results
//   tag_underflow                        sticky: result arrived with no tag
// -----------------------------------------------------------------------------
module fir_share_arb #(
  parameter int CREDITS      = 4,
  parameter int ISSUE_GAP    = 0,
  parameter int DRAIN_CYCLES = 32
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic [23:0] left_in_data,
  input  logic        left_in_valid,
  output logic        left_in_ready,
  input  logic [23:0] right_in_data,
  input  logic        right_in_valid,
  output logic        right_in_ready,
  output logic [15:0] fir_in_data,
  output logic        fir_in_valid,
  output logic [1:0]  fir_in_error,
  input  logic [23:0] fir_out_data,
  input  logic        fir_out_valid,
  input  logic [1:0]  fir_out_error,
  output logic [23:0] left_out_data,
  output logic        left_out_valid,
  input  logic        left_out_ready,
  output logic [23:0] right_out_data,
  output logic        right_out_valid,
  input  logic        right_out_ready,
  output logic [7:0]  err_count,
  output logic        tag_underflow
);

  localparam int CW = $clog2(CREDITS) + 1;    // credit counter, 0..CREDITS
  localparam int PW = $clog2(CREDITS);        // output FIFO pointer
  localparam int TD = 2 * CREDITS;            // tag FIFO depth
  localparam int TW = $clog2(TD);             // tag FIFO pointer
  localparam int GW = $clog2(ISSUE_GAP + 2);  // gap counter
  localparam int DW = $clog2(DRAIN_CYCLES + 2);
  localparam int DRAIN_LAST_I = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;

  localparam logic [CW-1:0] CRED_INIT  = CW'(CREDITS);
  localparam logic [GW-1:0] GAP_LOAD   = GW'(ISSUE_GAP);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_LAST_I);

  typedef enum logic [0:0] {
    ST_DRAIN = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t          state_q;
  logic [DW-1:0]   drain_cnt_q;
  logic [CW-1:0]   cred_q [2];
  logic            ptr_q;            // 0: left has priority, 1: right
  logic [GW-1:0]   gap_q;
  logic            fir_in_valid_q;
  logic [15:0]     fir_in_data_q;
  logic [7:0]      err_q;
  logic            unf_q;

  logic            tag_mem_q [TD];
  logic [TW-1:0]   twr_q;
  logic [TW-1:0]   trd_q;
  logic [TW:0]     tcnt_q;

  logic [23:0]     omem_q [2][CREDITS];
  logic [PW-1:0]   owr_q [2];
  logic [PW-1:0]   ord_q [2];
  logic [PW:0]     ocnt_q [2];

  logic            run_s;
  logic [1:0]      in_valid_s;
  logic [1:0]      out_ready_s;
  logic [1:0]      elig_s;
  logic [1:0]      grant_s;
  logic [1:0]      out_valid_s;
  logic [1:0]      pop_s;
  logic [1:0]      push_s;
  logic            acc_s;
  logic [23:0]     acc_data_s;
  logic [15:0]     narrow_s;
  logic            ret_s;
  logic            tag_hit_s;
  logic            ret_tag_s;
  logic            unused_lsbs_s;

  assign run_s       = (state_q == ST_RUN);
  assign in_valid_s  = {right_in_valid, left_in_valid};
  assign out_ready_s = {right_out_ready, left_out_ready};

  // Eligibility and round-robin grant; at most one grant bit is ever set.
  always_comb begin
    elig_s  = 2'b00;
    grant_s = 2'b00;
    for (int c = 0; c < 2; c++) begin
      elig_s[c] = run_s && (gap_q == GW'(0)) && in_valid_s[c] &&
                  (cred_q[c] != CW'(0));
    end
    case (elig_s)
      2'b01:   grant_s = 2'b01;
      2'b10:   grant_s = 2'b10;
      2'b11:   grant_s = ptr_q ? 2'b10 : 2'b01;
      default: grant_s = 2'b00;
    endcase
  end

  assign left_in_ready  = grant_s[0];
  assign right_in_ready = grant_s[1];
  assign acc_s          = grant_s[0] | grant_s[1];
  assign acc_data_s     = grant_s[1] ? right_in_data : left_in_data;

`ifdef FIR_SHARE_ARB_ROUND_EN
  // Round half up; only the most positive code can overflow, so clamp it.
  function automatic logic [15:0] round_sat(input logic [15:0] hi,
                                            input logic rnd);
    logic [15:0] res;
    if (rnd && (hi != 16'h7FFF)) begin
      res = hi + 16'h0001;
    end else begin
      res = hi;
    end
    return res;
  endfunction

  assign narrow_s = round_sat(acc_data_s[23:8], acc_data_s[7]);
`else
  assign narrow_s = acc_data_s[23:8];
`endif

  // The low byte only matters for rounding; gather it to mark it as intended.
  assign unused_lsbs_s = ^{left_in_data[7:0], right_in_data[7:0]};

  // Return path: results are only meaningful in RUN and need a pending tag.
  assign ret_s     = run_s & fir_out_valid;
  assign tag_hit_s = ret_s & (tcnt_q != (TW + 1)'(0));
  assign ret_tag_s = tag_mem_q[trd_q];
  assign push_s[0] = tag_hit_s & ~ret_tag_s;
  assign push_s[1] = tag_hit_s & ret_tag_s;

  assign out_valid_s[0] = (ocnt_q[0] != (PW + 1)'(0));
  assign out_valid_s[1] = (ocnt_q[1] != (PW + 1)'(0));
  assign pop_s          = out_valid_s & out_ready_s;

  assign fir_in_data     = fir_in_data_q;
  assign fir_in_valid    = fir_in_valid_q;
  assign fir_in_error    = 2'b00;
  assign left_out_valid  = out_valid_s[0];
  assign right_out_valid = out_valid_s[1];
  assign left_out_data   = out_valid_s[0] ? omem_q[0][ord_q[0]] : 24'h000000;
  assign right_out_data  = out_valid_s[1] ? omem_q[1][ord_q[1]] : 24'h000000;
  assign err_count       = err_q;
  assign tag_underflow   = unf_q;

  // DRAIN -> RUN sequencing after reset.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q     <= ST_DRAIN;
      drain_cnt_q <= DW'(0);
    end else begin
      case (state_q)
        ST_DRAIN: begin
          if (drain_cnt_q >= DRAIN_LAST) begin
            state_q <= ST_RUN;
          end else begin
            drain_cnt_q <= drain_cnt_q + DW'(1);
          end
        end
        ST_RUN:  state_q <= ST_RUN;
        default: state_q <= ST_DRAIN;
      endcase
    end
  end

  // Issue register, gap counter, priority pointer, credits and status.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      ptr_q          <= 1'b0;
      gap_q          <= GW'(0);
      fir_in_valid_q <= 1'b0;
      fir_in_data_q  <= 16'h0000;
      err_q          <= 8'h00;
      unf_q          <= 1'b0;
      cred_q[0]      <= CRED_INIT;
      cred_q[1]      <= CRED_INIT;
    end else begin
      fir_in_valid_q <= acc_s;
      if (acc_s) begin
        fir_in_data_q <= narrow_s;
        gap_q         <= GAP_LOAD;
        ptr_q         <= grant_s[0];  // priority moves to the other channel
      end else if (gap_q != GW'(0)) begin
        gap_q <= gap_q - GW'(1);
      end
      for (int c = 0; c < 2; c++) begin
        case ({grant_s[c], pop_s[c]})
          2'b10:   cred_q[c] <= cred_q[c] - CW'(1);
          2'b01:   cred_q[c] <= cred_q[c] + CW'(1);
          default: cred_q[c] <= cred_q[c];
        endcase
      end
      if (ret_s && (fir_out_error != 2'b00) && (err_q != 8'hFF)) begin
        err_q <= err_q + 8'h01;
      end
      if (ret_s && !tag_hit_s) begin
        unf_q <= 1'b1;
      end
    end
  end

  // Tag FIFO pointers and occupancy.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      twr_q  <= TW'(0);
      trd_q  <= TW'(0);
      tcnt_q <= (TW + 1)'(0);
    end else begin
      if (acc_s) begin
        twr_q <= twr_q + TW'(1);
      end
      if (tag_hit_s) begin
        trd_q <= trd_q + TW'(1);
      end
      case ({acc_s, tag_hit_s})
        2'b10:   tcnt_q <= tcnt_q + (TW + 1)'(1);
        2'b01:   tcnt_q <= tcnt_q - (TW + 1)'(1);
        default: tcnt_q <= tcnt_q;
      endcase
    end
  end

  // Tag storage; occupancy gates every read, so no reset is needed.
  always_ff @(posedge clk_clk) begin
    if (acc_s) begin
      tag_mem_q[twr_q] <= grant_s[1];
    end
  end

  // Output FIFO pointers and occupancy, one FIFO per channel.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      for (int c = 0; c < 2; c++) begin
        owr_q[c]  <= PW'(0);
        ord_q[c]  <= PW'(0);
        ocnt_q[c] <= (PW + 1)'(0);
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (push_s[c]) begin
          owr_q[c] <= owr_q[c] + PW'(1);
        end
        if (pop_s[c]) begin
          ord_q[c] <= ord_q[c] + PW'(1);
        end
        case ({push_s[c], pop_s[c]})
          2'b10:   ocnt_q[c] <= ocnt_q[c] + (PW + 1)'(1);
          2'b01:   ocnt_q[c] <= ocnt_q[c] - (PW + 1)'(1);
          default: ocnt_q[c] <= ocnt_q[c];
        endcase
      end
    end
  end

  // Output FIFO storage; the data outputs are gated by occupancy.
  always_ff @(posedge clk_clk) begin
    for (int c = 0; c < 2; c++) begin
      if (push_s[c]) begin
        omem_q[c][owr_q[c]] <= fir_out_data;
      end
    end
  end

endmodule

// File: tb/tb_fir_share_arb.sv
// Testbench for fir_share_arb: random and directed stimulus compared against
// a transaction-level model (credit counts, tag queue, output queues, FIR
// delay line). A second instance with ISSUE_GAP=3 checks issue spacing.
module tb_fir_share_arb;

  localparam int CREDITS = 4;
  localparam int DRAIN   = 32;
  localparam int LAT     = 5;

`ifdef FIR_SHARE_ARB_ROUND_EN
  localparam logic [15:0] EXP_123480 = 16'h1235;
`else
  localparam logic [15:0] EXP_123480 = 16'h1234;
`endif

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_reset;
  logic [23:0] left_in_data, right_in_data;
  logic        left_in_valid, right_in_valid, left_in_ready, right_in_ready;
  logic [15:0] fir_in_data;
  logic        fir_in_valid;
  logic [1:0]  fir_in_error;
  logic [23:0] fir_out_data;
  logic        fir_out_valid;
  logic [1:0]  fir_out_error;
  logic [23:0] left_out_data, right_out_data;
  logic        left_out_valid, right_out_valid, left_out_ready, right_out_ready;
  logic [7:0]  err_count;
  logic        tag_underflow;

  fir_share_arb #(.CREDITS(CREDITS), .ISSUE_GAP(0), .DRAIN_CYCLES(DRAIN)) dut (
    .clk_clk(clk), .reset_reset(reset_reset),
    .left_in_data(left_in_data), .left_in_valid(left_in_valid), .left_in_ready(left_in_ready),
    .right_in_data(right_in_data), .right_in_valid(right_in_valid), .right_in_ready(right_in_ready),
    .fir_in_data(fir_in_data), .fir_in_valid(fir_in_valid), .fir_in_error(fir_in_error),
    .fir_out_data(fir_out_data), .fir_out_valid(fir_out_valid), .fir_out_error(fir_out_error),
    .left_out_data(left_out_data), .left_out_valid(left_out_valid), .left_out_ready(left_out_ready),
    .right_out_data(right_out_data), .right_out_valid(right_out_valid), .right_out_ready(right_out_ready),
    .err_count(err_count), .tag_underflow(tag_underflow)
  );

  // Gap instance: inputs always valid, FIR loops straight back.
  logic        g_rst;
  logic        g_lrdy, g_rrdy, g_fiv, g_lov, g_rov, g_unf;
  logic [15:0] g_fid;
  logic [1:0]  g_fie;
  logic [23:0] g_lod, g_rod;
  logic [7:0]  g_err;

  fir_share_arb #(.CREDITS(CREDITS), .ISSUE_GAP(3), .DRAIN_CYCLES(DRAIN)) dut_gap (
    .clk_clk(clk), .reset_reset(g_rst),
    .left_in_data(24'h111111), .left_in_valid(1'b1), .left_in_ready(g_lrdy),
    .right_in_data(24'h222222), .right_in_valid(1'b1), .right_in_ready(g_rrdy),
    .fir_in_data(g_fid), .fir_in_valid(g_fiv), .fir_in_error(g_fie),
    .fir_out_data({g_fid, 8'h00}), .fir_out_valid(g_fiv), .fir_out_error(2'b00),
    .left_out_data(g_lod), .left_out_valid(g_lov), .left_out_ready(1'b1),
    .right_out_data(g_rod), .right_out_valid(g_rov), .right_out_ready(1'b1),
    .err_count(g_err), .tag_underflow(g_unf)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // stimulus knobs
  int pv_l, pv_r, pr_l, pr_r, dmode, err_mode;
  bit inj, rst;

  // reference model state
  int          m_drain_left;
  int          m_cred [2];
  int          m_ptr, m_gap, m_err;
  bit          m_unf, m_fiv;
  logic [15:0] m_fid;
  int          m_tags [$];
  logic [23:0] m_oq0 [$];
  logic [23:0] m_oq1 [$];
  int          pipe_due [$];
  logic [23:0] pipe_dat [$];
  int          m_lacc;

  int          dut_acc [2];
  bit          pend;
  logic [15:0] pend_exp;
  int          g_last = -1;
  int          g_pulses = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Spec narrowing: arithmetic shift by 8, optionally rounded and clamped.
  function automatic logic [15:0] exp_narrow(input logic [23:0] d);
    int v;
    v = int'($signed(d));
`ifdef FIR_SHARE_ARB_ROUND_EN
    v = (v + 128) >>> 8;
    if (v > 32767) v = 32767;
`else
    v = v >>> 8;
`endif
    return 16'(v);
  endfunction

  task automatic model_reset();
    m_drain_left = DRAIN;
    m_cred[0] = CREDITS; m_cred[1] = CREDITS;
    m_ptr = 0; m_gap = 0; m_err = 0; m_unf = 1'b0;
    m_fiv = 1'b0; m_fid = 16'h0000;
    m_tags.delete(); m_oq0.delete(); m_oq1.delete();
  endtask

  task automatic step();
    logic [1:0]  v, r, grant;
    logic [23:0] d0, d1, fod, dacc;
    logic        fov;
    logic [1:0]  foe;
    bit          run;
    bit [1:0]    elig;
    int          c;
    @(negedge clk);
    v[0] = ($urandom_range(0, 99) < pv_l);
    v[1] = ($urandom_range(0, 99) < pv_r);
    r[0] = ($urandom_range(0, 99) < pr_l);
    r[1] = ($urandom_range(0, 99) < pr_r);
    case (dmode)
      1: begin
        d0 = 24'h100000 + 24'($urandom_range(0, 127));
        d1 = 24'h200000 + 24'($urandom_range(0, 127));
      end
      2: begin
        d0 = (m_lacc % 2 == 0) ? 24'h7FFFC0 : 24'h123480;
        d1 = 24'h800080;
      end
      default: begin
        d0 = 24'($urandom);
        d1 = 24'($urandom);
      end
    endcase
    fov = 1'b0; fod = 24'($urandom); foe = 2'b00;
    if (pipe_due.size() > 0 && pipe_due[0] == cyc) begin
      fov = 1'b1;
      fod = pipe_dat.pop_front();
      void'(pipe_due.pop_front());
    end else if (inj && pipe_due.size() == 0) begin
      fov = 1'b1;
    end
    if (fov) begin
      if (err_mode == 1) foe = 2'b01;
      else if (err_mode == 2 && $urandom_range(0, 3) == 0) foe = 2'($urandom_range(1, 3));
    end
    reset_reset = rst;
    left_in_valid = v[0];  left_in_data = d0;  left_out_ready = r[0];
    right_in_valid = v[1]; right_in_data = d1; right_out_ready = r[1];
    fir_out_valid = fov;   fir_out_data = fod; fir_out_error = foe;
    #1;
    // expected outputs from the model state
    run = (m_drain_left == 0);
    for (int k = 0; k < 2; k++) elig[k] = run && (m_gap == 0) && v[k] && (m_cred[k] > 0);
    grant = 2'b00;
    if (elig == 2'b11) grant = (m_ptr == 0) ? 2'b01 : 2'b10;
    else grant = elig;
    check("left_in_ready", left_in_ready, grant[0]);
    check("right_in_ready", right_in_ready, grant[1]);
    check("fir_in_valid", fir_in_valid, m_fiv);
    if (m_fiv) check("fir_in_data", fir_in_data, m_fid);
    check("fir_in_error", fir_in_error, 2'b00);
    check("left_out_valid", left_out_valid, m_oq0.size() > 0);
    check("right_out_valid", right_out_valid, m_oq1.size() > 0);
    if (m_oq0.size() > 0) check("left_out_data", left_out_data, m_oq0[0]);
    if (m_oq1.size() > 0) check("right_out_data", right_out_data, m_oq1[0]);
    check("err_count", err_count, m_err);
    check("tag_underflow", tag_underflow, m_unf);
    if (pend) begin
      check("narrow_const", fir_in_data, pend_exp);
      pend = 1'b0;
    end
    if (g_fiv) begin
      if (g_last >= 0) check("gap_spacing", cyc - g_last, 4);
      g_last = cyc;
      g_pulses++;
    end
    // advance the model across the coming edge
    if (rst) begin
      model_reset();
    end else begin
      if (left_in_valid && left_in_ready) dut_acc[0]++;
      if (right_in_valid && right_in_ready) dut_acc[1]++;
      if (m_oq0.size() > 0 && r[0]) begin void'(m_oq0.pop_front()); m_cred[0]++; end
      if (m_oq1.size() > 0 && r[1]) begin void'(m_oq1.pop_front()); m_cred[1]++; end
      if (grant != 2'b00) begin
        c = grant[1] ? 1 : 0;
        dacc = (c == 1) ? d1 : d0;
        if (c == 0) m_lacc++;
        m_cred[c]--;
        m_tags.push_back(c);
        m_ptr = 1 - c;
        m_gap = 0;
        m_fiv = 1'b1;
        m_fid = exp_narrow(dacc);
        if (dacc == 24'h123480) begin pend = 1'b1; pend_exp = EXP_123480; end
        if (dacc == 24'h7FFFC0) begin pend = 1'b1; pend_exp = 16'h7FFF; end
        pipe_due.push_back(cyc + 1 + LAT);
        pipe_dat.push_back(24'($urandom));
      end else begin
        m_fiv = 1'b0;
      end
      if (fov && run) begin
        if (foe != 2'b00 && m_err < 255) m_err++;
        if (m_tags.size() == 0) begin
          m_unf = 1'b1;
        end else begin
          c = m_tags.pop_front();
          if (c == 0) m_oq0.push_back(fod);
          else m_oq1.push_back(fod);
        end
      end
      if (m_drain_left > 0) m_drain_left--;
    end
    cyc++;
  endtask

  initial begin
    reset_reset = 1'b1; g_rst = 1'b1;
    left_in_valid = 1'b0; right_in_valid = 1'b0;
    left_in_data = 24'h0; right_in_data = 24'h0;
    left_out_ready = 1'b0; right_out_ready = 1'b0;
    fir_out_valid = 1'b0; fir_out_data = 24'h0; fir_out_error = 2'b00;
    pv_l = 0; pv_r = 0; pr_l = 100; pr_r = 100; dmode = 0; err_mode = 0;
    inj = 1'b0; rst = 1'b1; pend = 1'b0; m_lacc = 0;
    dut_acc[0] = 0; dut_acc[1] = 0;
    model_reset();
    repeat (2) @(posedge clk);
    g_rst = 1'b0;

    // reset values
    step();
    check("rst_left_out_data", left_out_data, 24'h0);
    check("rst_right_out_data", right_out_data, 24'h0);
    check("rst_fir_in_data", fir_in_data, 16'h0);
    rst = 1'b0;

    // DRAIN: inputs valid, unsolicited results ignored
    pv_l = 100; pv_r = 100; inj = 1'b1;
    repeat (DRAIN) step();
    inj = 1'b0;

    // alternation
    dmode = 1;
    repeat (60) step();

    // credit stall on left
    pv_l = 0; pv_r = 0;
    repeat (20) step();
    dut_acc[0] = 0; dut_acc[1] = 0;
    pv_l = 100; pv_r = 100; pr_l = 0;
    repeat (30) step();
    check("stall_left_accepts", dut_acc[0], 4);
    check("stall_right_flows", dut_acc[1] > 10, 1'b1);
    dut_acc[0] = 0;
    pr_l = 100; step(); pr_l = 0;
    repeat (10) step();
    check("stall_one_more_left", dut_acc[0], 1);
    pr_l = 100; pv_l = 0; pv_r = 0;
    repeat (20) step();

    // narrowing
    dmode = 2; pv_l = 100; pv_r = 50;
    repeat (40) step();

    // random traffic
    dmode = 0; err_mode = 2;
    pv_l = 60; pv_r = 40; pr_l = 70; pr_r = 50;
    repeat (1500) step();

    // errored results saturate the counter
    err_mode = 1; pv_l = 100; pv_r = 100; pr_l = 100; pr_r = 100;
    repeat (350) step();
    check("err_saturated", err_count, 8'd255);
    err_mode = 0;

    // unsolicited result in RUN
    pv_l = 0; pv_r = 0;
    repeat (20) step();
    inj = 1'b1; step(); inj = 1'b0;
    step();
    check("underflow_sticky", tag_underflow, 1'b1);

    // reset with three samples inside the FIR
    pv_l = 100; pv_r = 100;
    repeat (3) step();
    check("inflight_before_reset", m_tags.size(), 3);
    pv_l = 0; pv_r = 0; rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (40) step();
    check("reset_underflow_clear", tag_underflow, 1'b0);
    dut_acc[0] = 0; dut_acc[1] = 0;
    pv_l = 100; pv_r = 100; pr_l = 0;
    repeat (30) step();
    check("reset_credits_left", dut_acc[0], 4);

    check("gap_pulses_seen", g_pulses > 100, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
